// File: rtl/ternary_serial_multiplier.sv
// ternary_serial_multiplier
//   Sequential N-trit x N-trit unsigned ternary multiplier. Each MUL cycle
//   forms one partial-product row (latched a times one trit of b). It adds
//   that row into a 2N-trit accumulator at the row's trit offset.
//   Trit code: 00=0, 01=1, 10=2, 11=illegal.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request a multiply (sampled in IDLE only)
//   a, b  : N-trit operands, trit 0 in bits [1:0]
//   p     : 2N-trit product, updated when DONE is entered
//   busy  : high during MUL and DONE
//   done  : one-cycle pulse, p valid
//   err   : sticky flag, illegal trit seen on a start request
module ternary_serial_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic [4*N-1:0] p,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int JW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             busy_r;
  logic             done_r;
  logic             busy_s;
  logic             done_s;
  logic             err_r;
  logic [2*N-1:0]   a_r;
  logic [2*N-1:0]   b_r;
  logic [4*N-1:0]   acc_r;
  logic [4*N-1:0]   p_r;
  logic [JW-1:0]    j_r;

  logic             ops_legal_s;
  logic             last_row_s;
  logic [2*N+1:0]   row_s;
  logic [3:0]       row_mp_s;
  logic [3:0]       row_ad_s;
  logic [1:0]       row_mc_s;
  logic [1:0]       row_rc_s;
  logic [4*N-1:0]   row_ext_s;
  logic [4*N-1:0]   acc_sum_s;
  logic [3:0]       acc_t_s;
  logic [1:0]       acc_c_s;
  logic             acc_cout_s;

  // One ternary digit add: returns {carry, sum}, sum = (x+y+c) mod 3.
  function automatic logic [3:0] trit_add(input logic [1:0] x,
                                          input logic [1:0] y,
                                          input logic [1:0] c);
    logic [2:0] s;
    logic [3:0] r;
    s = {1'b0, x} + {1'b0, y} + {1'b0, c};
    case (s)
      3'd0:    r = {2'd0, 2'd0};
      3'd1:    r = {2'd0, 2'd1};
      3'd2:    r = {2'd0, 2'd2};
      3'd3:    r = {2'd1, 2'd0};
      3'd4:    r = {2'd1, 2'd1};
      3'd5:    r = {2'd1, 2'd2};
      3'd6:    r = {2'd2, 2'd0};
      default: r = {2'd0, 2'd0};
    endcase
    return r;
  endfunction

  // Single-trit multiplier: returns {carry, product}.
  function automatic logic [3:0] trit_mul(input logic [1:0] x,
                                          input logic [1:0] y);
    logic [3:0] m;
    logic [3:0] r;
    m = {2'b00, x} * {2'b00, y};
    case (m)
      4'd0:    r = {2'd0, 2'd0};
      4'd1:    r = {2'd0, 2'd1};
      4'd2:    r = {2'd0, 2'd2};
      4'd4:    r = {2'd1, 2'd1};
      default: r = {2'd0, 2'd0};
    endcase
    return r;
  endfunction

  // True when no trit of v carries the illegal code 11.
  function automatic logic trits_legal(input logic [2*N-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      ok = ok & (v[2*i +: 2] != 2'b11);
    end
    return ok;
  endfunction

  assign ops_legal_s = trits_legal(a) & trits_legal(b);
  assign last_row_s  = (j_r == JW'(N - 1));

  // Partial-product row: latched a times the current b trit (b_r[1:0]).
  // The multiplier carries and the ripple carries are folded into N+1 trits.
  always_comb begin
    row_s    = {(2*N+2){1'b0}};
    row_mp_s = 4'd0;
    row_ad_s = 4'd0;
    row_mc_s = 2'd0;
    row_rc_s = 2'd0;
    for (int i = 0; i < N; i++) begin
      row_mp_s            = trit_mul(a_r[2*i +: 2], b_r[1:0]);
      row_ad_s            = trit_add(row_mp_s[1:0], row_mc_s, row_rc_s);
      row_s[2*i +: 2]     = row_ad_s[1:0];
      row_rc_s            = row_ad_s[3:2];
      row_mc_s            = row_mp_s[3:2];
    end
    row_ad_s          = trit_add(2'd0, row_mc_s, row_rc_s);
    row_s[2*N +: 2]   = row_ad_s[1:0];
  end

  // Accumulate the row, shifted up by j trits, with a ternary ripple adder.
  always_comb begin
    row_ext_s  = {{(2*N-2){1'b0}}, row_s} << {j_r, 1'b0};
    acc_sum_s  = {(4*N){1'b0}};
    acc_t_s    = 4'd0;
    acc_c_s    = 2'd0;
    for (int k = 0; k < 2*N; k++) begin
      acc_t_s               = trit_add(acc_r[2*k +: 2], row_ext_s[2*k +: 2], acc_c_s);
      acc_sum_s[2*k +: 2]   = acc_t_s[1:0];
      acc_c_s               = acc_t_s[3:2];
    end
    // Always zero because the product fits in 2N trits.
    acc_cout_s = (acc_c_s != 2'd0);
  end

  // FSM state register with registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && ops_legal_s) begin
          next_state_s = MUL;
        end else begin
          next_state_s = IDLE;
        end
      end
      MUL: begin
        if (last_row_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = MUL;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so the flops line up with it.
  always_comb begin
    busy_s = (next_state_s != IDLE);
    done_s = (next_state_s == DONE);
  end

  // Datapath: operand latch, accumulator, row index, result and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {(2*N){1'b0}};
      b_r   <= {(2*N){1'b0}};
      acc_r <= {(4*N){1'b0}};
      p_r   <= {(4*N){1'b0}};
      j_r   <= {JW{1'b0}};
      err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && ops_legal_s) begin
            a_r   <= a;
            b_r   <= b;
            acc_r <= {(4*N){1'b0}};
            j_r   <= {JW{1'b0}};
            err_r <= 1'b0;
          end else if (start) begin
            err_r <= 1'b1;
          end else begin
            err_r <= err_r;
          end
        end
        MUL: begin
          acc_r <= acc_sum_s;
          // Shift b so the trit for the next row is always in b_r[1:0].
          b_r   <= {2'b00, b_r[2*N-1:2]};
          j_r   <= j_r + JW'(1);
          if (last_row_s) begin
            p_r <= acc_sum_s;
          end else begin
            p_r <= p_r;
          end
        end
        DONE: begin
          j_r <= {JW{1'b0}};
        end
        default: begin
          j_r <= {JW{1'b0}};
        end
      endcase
    end
  end

  assign p    = p_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_ternary_serial_multiplier.sv
// Scoreboard bench for ternary_serial_multiplier (N=4). Stimulus pushes
// hand-computed products into exp_q. A monitor pops one entry on every done
// pulse and compares it with p.
module tb_ternary_serial_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] p;
  logic        busy;
  logic        done;
  logic        err;

  int          n_vec;
  int          n_miss;
  int          cout_bad;
  logic [15:0] exp_q[$];

  ternary_serial_multiplier #(.N(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: compare p against the scoreboard whenever done pulses.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst === 1'b0 && done === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_done: p=%h, no result was expected", p);
      end else begin
        e = exp_q.pop_front();
        if (p !== e) begin
          n_miss++;
          $display("FAIL product: got %h expected %h", p, e);
        end
      end
    end
  end

  // The accumulator must never carry out past the top trit during MUL.
  always @(negedge clk) begin
    if (rst === 1'b0 && busy === 1'b1 && done === 1'b0 && dut.acc_cout_s !== 1'b0) begin
      cout_bad++;
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] expv,
                        input string nm);
    int cyc;
    int bcnt;
    a = ta;
    b = tb;
    start = 1'b1;
    exp_q.push_back(expv);
    cyc = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) bcnt++;
    end while (!done && cyc < 20);
    check({nm, "_latency"}, 32'(cyc), 32'd5);
    check({nm, "_busy_cycles"}, 32'(bcnt), 32'd5);
    @(negedge clk);
    check({nm, "_done_single"}, 32'(done), 32'd0);
    check({nm, "_busy_clear"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    n_vec = 0;
    n_miss = 0;
    cout_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_p", 32'(p), 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    run_op(8'hAA, 8'h00, 16'h0000, "zero");
    run_op(8'h06, 8'h01, 16'h0006, "identity");
    run_op(8'h02, 8'h02, 16'h0005, "carry_2x2");
    run_op(8'h06, 8'h09, 16'h004A, "general_5x7");
    run_op(8'hAA, 8'hAA, 16'hA901, "max");
    run_op(8'h09, 8'h06, 16'h004A, "general_7x5");

    // Illegal trit on a: err sets, nothing else moves.
    a = 8'h03;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    check("illegal_p_hold", 32'(p), 32'h004A);
    repeat (3) @(negedge clk);
    check("illegal_err_sticky", 32'(err), 32'd1);
    check("illegal_busy_idle", 32'(busy), 32'd0);

    // Valid start, then a second start two cycles later that must be ignored.
    a = 8'h06;
    b = 8'h09;
    start = 1'b1;
    exp_q.push_back(16'h004A);
    @(negedge clk);
    start = 1'b0;
    check("accept_err_clear", 32'(err), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
    @(negedge clk);
    a = 8'h02;
    b = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ignored_start_done_seen", 32'(done), 32'd1);
    repeat (8) @(negedge clk);
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Reset during the second MUL cycle abandons the operation.
    a = 8'hAA;
    b = 8'hAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_p", 32'(p), 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    repeat (7) @(negedge clk);
    check("midrst_no_done", 32'(busy), 32'd0);
    run_op(8'hAA, 8'hAA, 16'hA901, "after_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("acc_carry_out", 32'(cout_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ternary_serial_multiplier.md
Name: ternary_serial_multiplier

Overview:
Sequential N-trit × N-trit unsigned ternary multiplier built around the single-trit ternary_multiplier, which produces a product trit and a carry trit. Each cycle it forms one partial-product row (operand A × one trit of B) and accumulates it, shifted by trit position, into a 2N-trit result register. It consumes the per-trit product/carry outputs and presents a full-width product to downstream ternary arithmetic under a start/done handshake.

Parameters:
N, 4, operand width in trits; each trit is 2 bits, so operands are 2N bits and the product is 4N bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
a  input  2N  multiplicand, N trits, trit 0 in bits [1:0]
b  input  2N  multiplier, N trits, trit 0 in bits [1:0]
p  output  4N  product, 2N trits, trit 0 in bits [1:0]
busy  output  1  high while an operation is in progress (MUL and DONE states)
done  output  1  one-cycle pulse; p is valid in that cycle
err  output  1  illegal trit code seen on a or b at start; sticky

Behaviour:
- Trit encoding: 00=0, 01=1, 10=2; 11 is illegal. Unbalanced ternary, unsigned.
- Reset (rst=1 at an edge, from any state including mid-operation): state=IDLE, p=0, busy=0, done=0, err=0, row index j=0. Any operation in flight is abandoned.
- States:
  - IDLE: busy=0. If start=1 and every trit of a and b is legal: latch a and b into internal registers, clear the accumulator to 0, set j=0, clear err, go to MUL. If start=1 with any 11 trit: set err=1, stay in IDLE, p unchanged, done not asserted.
  - MUL: busy=1. Each cycle, compute row = latched_a × b_j using N single-trit multipliers plus a ternary ripple carry chain, giving N+1 trits. Add the row into the accumulator at trit offset j using a ternary ripple adder, with sum digit (x+y+c) mod 3 and carry (x+y+c) div 3. Increment j. After the row with j=N-1, go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle, p = accumulator. Next state is IDLE.
- Latency: if start is accepted at edge t, MUL occupies cycles t+1 through t+N and done=1 in cycle t+N+1. A new start is accepted no earlier than the IDLE cycle t+N+2.
- start while busy=1 is ignored; no queueing. a and b may change freely after acceptance because they are latched.
- p updates only when entering DONE and otherwise holds its last result, including across IDLE and a rejected start. Internal accumulator state is never exposed mid-operation.
- Overflow cannot occur: (3^N−1)^2 < 3^(2N). Accumulator carry-out past trit 2N−1 is always 0; the bench asserts this.
- No output ever carries the code 11.
- err clears only on reset or on the next accepted start.

Test Plan:
- Zero/identity: N=4, a=8'hAA (2222₃), b=8'h00 -> done at start+5 cycles, p=16'h0000. Then a=8'h06, b=8'h01 -> p=16'h0006.
- Single-trit carry: a=8'h02, b=8'h02 (2×2) -> p=16'h0005 (11₃ = 4).
- General: a=8'h06 (0012₃=5), b=8'h09 (0021₃=7) -> p=16'h004A (00001022₃=35). busy is high for exactly 5 cycles and done pulses once.
- Maximum: a=b=8'hAA (80) -> p=16'hA901 (22210001₃=6400). No carry-out past the top trit.
- Illegal/ignored start: a=8'h03 with start -> err=1 next cycle, busy stays 0, no done, p unchanged. Next, a valid start followed by a second start pulse 2 cycles later with different operands -> only the first result appears and err clears.
- Reset mid-operation: assert rst in the 2nd MUL cycle -> next cycle p=0, busy=0, done=0, err=0. A fresh start then completes normally with the correct product.
